// File: rtl/bcd_scheduler.sv
// Round-robin arbiter sharing one iterative shift-add-3 binary-to-BCD engine
// among NREQ requesters; keeps a per-requester copy of the last result.
module bcd_scheduler #(
  parameter int NREQ  = 4,
  parameter int BIN_W = 10,
  parameter int DIG   = 3
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*BIN_W-1:0]    bin_in,
  output logic [NREQ-1:0]          ack,
  output logic [DIG*4-1:0]         dec_out,
  output logic [$clog2(NREQ)-1:0]  dec_id,
  output logic                     dec_ovf,
  output logic [NREQ*DIG*4-1:0]    dec_reg,
  output logic                     busy
);
  localparam int     IDW  = $clog2(NREQ);
  localparam int     CW   = $clog2(BIN_W + 1);
  localparam longint MAXV = 64'(10**DIG) - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e                        state_q;
  logic [CW-1:0]                 cnt_q;
  logic [BIN_W-1:0]              bin_q;
  logic [DIG*4-1:0]              dig_q;
  logic [IDW-1:0]                id_q, last_q;
  logic                          ovf_q;
  logic [NREQ-1:0]               ack_q;
  logic [DIG*4-1:0]              dec_out_q;
  logic [IDW-1:0]                dec_id_q;
  logic                          dec_ovf_q;
  logic [NREQ-1:0][DIG*4-1:0]    reg_q;

  logic                          gnt_vld;
  logic [IDW-1:0]                gnt_id;
  logic [BIN_W-1:0]              op_raw, op_sat;
  logic                          op_ovf;
  logic [DIG*4-1:0]              adj, dig_nx;
  logic [BIN_W-1:0]              bin_nx;

  // Scan from the farthest candidate down so the nearest one after last_q wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last_q) + k) % NREQ]) begin
        gnt_vld = 1'b1;
        gnt_id  = IDW'((int'(last_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    op_raw = bin_in[int'(gnt_id)*BIN_W +: BIN_W];
    op_ovf = longint'(op_raw) > MAXV;
    op_sat = op_ovf ? BIN_W'(MAXV) : op_raw;
  end

  // One double-dabble step: correct every digit, then shift the whole chain.
  always_comb begin
    adj = dig_q;
    for (int d = 0; d < DIG; d++)
      if (dig_q[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = dig_q[d*4 +: 4] + 4'd3;
    {dig_nx, bin_nx} = {adj, bin_q} << 1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bin_q     <= '0;
      dig_q     <= '0;
      id_q      <= '0;
      last_q    <= IDW'(NREQ - 1);
      ovf_q     <= 1'b0;
      ack_q     <= '0;
      dec_out_q <= '0;
      dec_id_q  <= '0;
      dec_ovf_q <= 1'b0;
      reg_q     <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: if (gnt_vld) begin
          id_q    <= gnt_id;
          bin_q   <= op_sat;
          ovf_q   <= op_ovf;
          dig_q   <= '0;
          cnt_q   <= CW'(BIN_W);
          state_q <= SHIFT;
        end
        SHIFT: begin
          dig_q <= dig_nx;
          bin_q <= bin_nx;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= DONE;
            ack_q[id_q] <= 1'b1;
            dec_out_q   <= dig_nx;
            dec_id_q    <= id_q;
            dec_ovf_q   <= ovf_q;
          end
        end
        DONE: begin
          reg_q[id_q] <= dec_out_q;
          last_q      <= id_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack     = ack_q;
  assign dec_out = dec_out_q;
  assign dec_id  = dec_id_q;
  assign dec_ovf = dec_ovf_q;
  assign dec_reg = reg_q;
  assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_bcd_scheduler.sv
// Randomized bench for bcd_scheduler against a decimal-arithmetic round-robin model.
module tb_bcd_scheduler;
  localparam int NREQ = 4, BIN_W = 10, DIG = 3;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic [3:0]    req = '0;
  logic [39:0]   bin_in = '0;
  logic [3:0]    ack;
  logic [11:0]   dec_out;
  logic [1:0]    dec_id;
  logic          dec_ovf;
  logic [47:0]   dec_reg;
  logic          busy;

  int checks = 0, fails = 0;
  int ops[4];
  logic [11:0] exp_reg[4];
  int last_m = 3;

  bcd_scheduler #(.NREQ(NREQ), .BIN_W(BIN_W), .DIG(DIG)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .bin_in(bin_in), .ack(ack),
    .dec_out(dec_out), .dec_id(dec_id), .dec_ovf(dec_ovf),
    .dec_reg(dec_reg), .busy(busy));

  always #5 Clk = ~Clk;

  function automatic logic [11:0] bcd(input int v);
    int s;
    s = (v > 999) ? 999 : v;
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic int rr(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic logic [47:0] reg_vec();
    return {exp_reg[3], exp_reg[2], exp_reg[1], exp_reg[0]};
  endfunction

  function automatic int rand_op();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 999;
      2: return int'($urandom_range(1000, 1023));
      default: return int'($urandom_range(0, 1023));
    endcase
  endfunction

  task automatic set_op(input int i, input int v);
    ops[i] = v;
    bin_in[i*10 +: 10] = 10'(v);
  endtask

  task automatic do_reset();
    req = '0;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) exp_reg[i] = '0;
    last_m = 3;
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      @(posedge Clk); @(negedge Clk); cyc++;
    end while (ack == '0 && cyc < 40);
    if (ack == '0) begin
      checks++; fails++;
      $display("FAIL ack_timeout got=no ack required=ack within 40 cycles");
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ack !== 4'h0) begin fails++; $display("FAIL rst_ack got=%h exp=0", ack); end
    checks++; if (dec_out !== 12'h000) begin fails++; $display("FAIL rst_dec_out got=%h exp=0", dec_out); end
    checks++; if (dec_id !== 2'd0) begin fails++; $display("FAIL rst_dec_id got=%0d exp=0", dec_id); end
    checks++; if (dec_ovf !== 1'b0) begin fails++; $display("FAIL rst_dec_ovf got=%b exp=0", dec_ovf); end
    checks++; if (dec_reg !== 48'h0) begin fails++; $display("FAIL rst_dec_reg got=%h exp=0", dec_reg); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int cyc;
    do_reset();
    set_op(1, 255);
    req = 4'b0010;
    wait_ack(cyc);
    checks++; if (cyc != 11) begin fails++; $display("FAIL basic_latency got=%0d exp=11", cyc); end
    checks++; if (ack !== 4'b0010) begin fails++; $display("FAIL basic_ack got=%b exp=0010", ack); end
    checks++; if (dec_out !== 12'h255) begin fails++; $display("FAIL basic_dec_out got=%h exp=255", dec_out); end
    checks++; if (dec_id !== 2'd1) begin fails++; $display("FAIL basic_dec_id got=%0d exp=1", dec_id); end
    checks++; if (dec_ovf !== 1'b0) begin fails++; $display("FAIL basic_ovf got=%b exp=0", dec_ovf); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_done got=%b exp=1", busy); end
    checks++; if (dec_reg !== 48'h0) begin fails++; $display("FAIL basic_slot_early got=%h exp=0", dec_reg); end
    req = '0;
    exp_reg[1] = 12'h255; last_m = 1;
    @(posedge Clk); @(negedge Clk);
    checks++; if (ack !== 4'h0) begin fails++; $display("FAIL basic_ack_pulse got=%b exp=0", ack); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_idle got=%b exp=0", busy); end
    checks++; if (dec_reg !== reg_vec()) begin fails++; $display("FAIL basic_slot got=%h exp=%h", dec_reg, reg_vec()); end
    checks++; if (dec_out !== 12'h255) begin fails++; $display("FAIL basic_hold got=%h exp=255", dec_out); end
  endtask

  task automatic test_boundary();
    int vals[8];
    int cyc;
    vals = '{0, 999, 1000, 1023, 512, rand_op(), rand_op(), int'($urandom_range(0, 1023))};
    for (int n = 0; n < 8; n++) begin
      set_op(0, vals[n]);
      req = 4'b0001;
      wait_ack(cyc);
      checks++; if (cyc != 11) begin fails++; $display("FAIL bnd_latency v=%0d got=%0d exp=11", vals[n], cyc); end
      checks++; if (ack !== 4'b0001) begin fails++; $display("FAIL bnd_ack v=%0d got=%b exp=0001", vals[n], ack); end
      checks++; if (dec_out !== bcd(vals[n])) begin fails++; $display("FAIL bnd_dec_out v=%0d got=%h exp=%h", vals[n], dec_out, bcd(vals[n])); end
      checks++; if (dec_ovf !== (vals[n] > 999)) begin fails++; $display("FAIL bnd_ovf v=%0d got=%b exp=%b", vals[n], dec_ovf, vals[n] > 999); end
      req = '0;
      exp_reg[0] = bcd(vals[n]); last_m = 0;
      @(posedge Clk); @(negedge Clk);
      checks++; if (dec_reg !== reg_vec()) begin fails++; $display("FAIL bnd_slot v=%0d got=%h exp=%h", vals[n], dec_reg, reg_vec()); end
    end
  endtask

  // Arbitration scenario: mask raised at once; drop = release on ack, rnd = random new arrivals.
  task automatic run_rr(input string nm, input logic [3:0] mask, input int n, input bit drop, input bit rnd);
    int cyc, e, j;
    logic [3:0] nb;
    for (int i = 0; i < 4; i++) if (mask[i]) set_op(i, rand_op());
    req = mask;
    for (int k = 0; k < n; k++) begin
      e = rr(last_m, req);
      wait_ack(cyc);
      checks++; if (cyc != ((k == 0) ? 11 : 12)) begin fails++; $display("FAIL %s_spacing k=%0d got=%0d exp=%0d", nm, k, cyc, (k == 0) ? 11 : 12); end
      checks++; if (ack !== 4'(1 << e)) begin fails++; $display("FAIL %s_ack k=%0d got=%b exp=%b", nm, k, ack, 4'(1 << e)); end
      checks++; if (dec_id !== 2'(e)) begin fails++; $display("FAIL %s_dec_id k=%0d got=%0d exp=%0d", nm, k, dec_id, e); end
      checks++; if (dec_out !== bcd(ops[e])) begin fails++; $display("FAIL %s_dec_out k=%0d got=%h exp=%h", nm, k, dec_out, bcd(ops[e])); end
      checks++; if (dec_ovf !== (ops[e] > 999)) begin fails++; $display("FAIL %s_ovf k=%0d got=%b exp=%b", nm, k, dec_ovf, ops[e] > 999); end
      checks++; if (dec_reg !== reg_vec()) begin fails++; $display("FAIL %s_slots k=%0d got=%h exp=%h", nm, k, dec_reg, reg_vec()); end
      exp_reg[e] = bcd(ops[e]); last_m = e;
      if (drop) req[e] = 1'b0;
      if (rnd) begin
        nb = 4'($urandom_range(0, 15)) & ~req;
        for (int i = 0; i < 4; i++) if (nb[i]) set_op(i, rand_op());
        req = req | nb;
        if (req == '0) begin
          j = int'($urandom_range(0, 3));
          set_op(j, rand_op());
          req[j] = 1'b1;
        end
      end
    end
    req = '0;
    @(posedge Clk); @(negedge Clk);
    checks++; if (dec_reg !== reg_vec()) begin fails++; $display("FAIL %s_final_slots got=%h exp=%h", nm, dec_reg, reg_vec()); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL %s_final_busy got=%b exp=0", nm, busy); end
  endtask

  task automatic test_all_four();
    do_reset();
    run_rr("all4", 4'b1111, 4, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_rr("alt", 4'b0101, 6, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    run_rr("rand", 4'($urandom_range(1, 15)), 30, 1'b1, 1'b1);
  endtask

  task automatic test_operand_change();
    int cyc;
    set_op(0, 100);
    req = 4'b0001;
    cyc = 0;
    do begin
      @(posedge Clk); @(negedge Clk); cyc++;
      if (cyc == 3) set_op(0, 700);
    end while (ack == '0 && cyc < 40);
    checks++; if (cyc != 11) begin fails++; $display("FAIL opchg_latency got=%0d exp=11", cyc); end
    checks++; if (dec_out !== 12'h100) begin fails++; $display("FAIL opchg_dec_out got=%h exp=100", dec_out); end
    req = '0;
    exp_reg[0] = 12'h100; last_m = 0;
    @(posedge Clk); @(negedge Clk);
  endtask

  task automatic test_reset_abort();
    int cyc, v;
    bit early;
    do_reset();
    set_op(3, rand_op());
    req = 4'b1000;
    early = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge Clk); @(negedge Clk);
      if (ack != '0) early = 1'b1;
    end
    checks++; if (early) begin fails++; $display("FAIL abort_early_ack got=ack exp=none"); end
    Reset = 1'b1; req = '0;
    @(posedge Clk); @(negedge Clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (ack !== 4'h0) begin fails++; $display("FAIL abort_ack got=%b exp=0", ack); end
    checks++; if (dec_reg !== 48'h0) begin fails++; $display("FAIL abort_slots got=%h exp=0", dec_reg); end
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) exp_reg[i] = '0;
    last_m = 3;
    v = rand_op();
    set_op(3, v);
    req = 4'b1000;
    wait_ack(cyc);
    checks++; if (cyc != 11) begin fails++; $display("FAIL abort_fresh_latency got=%0d exp=11", cyc); end
    checks++; if (ack !== 4'b1000) begin fails++; $display("FAIL abort_fresh_ack got=%b exp=1000", ack); end
    checks++; if (dec_out !== bcd(v)) begin fails++; $display("FAIL abort_fresh_dec_out got=%h exp=%h", dec_out, bcd(v)); end
    checks++; if (dec_id !== 2'd3) begin fails++; $display("FAIL abort_fresh_dec_id got=%0d exp=3", dec_id); end
    req = '0;
    exp_reg[3] = bcd(v); last_m = 3;
    @(posedge Clk); @(negedge Clk);
    checks++; if (dec_reg !== reg_vec()) begin fails++; $display("FAIL abort_fresh_slot got=%h exp=%h", dec_reg, reg_vec()); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin ops[i] = 0; exp_reg[i] = '0; end
    test_reset();
    test_basic();
    test_boundary();
    test_all_four();
    test_back_to_back();
    test_operand_change();
    test_random();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
